// File: rtl/stats_uart_reporter_if.sv
// Signal bundle between the pet core and the telemetry UART transmitter.
// The core drives the stat snapshot inputs and triggers; the reporter drives the serial line and status.
interface stats_uart_reporter_if;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic [6:0] status;
  // send_req is a one-cycle request. A request that arrives while a packet is
  // going out is queued one deep. Any further request during that time is dropped.
  logic       send_req;
  logic       auto_en;
  logic       uart_tx;
  logic       busy;
  logic       pkt_done;
  logic [1:0] fsm_state;

  modport master (
    output hunger, happiness, health, hygiene, energy, social, status, send_req, auto_en,
    input  uart_tx, busy, pkt_done, fsm_state
  );

  modport slave (
    input  hunger, happiness, health, hygiene, energy, social, status, send_req, auto_en,
    output uart_tx, busy, pkt_done, fsm_state
  );
endinterface

// File: rtl/stats_uart_reporter.sv
// Telemetry transmitter: snapshots the pet stats and status and sends them as a 6-byte
// 8N1 UART packet on request, or periodically while auto_en is high.
module stats_uart_reporter #(
    parameter int          CLKS_PER_BIT  = 87,
    parameter logic [23:0] REPORT_PERIOD = 24'd10_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    stats_uart_reporter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int          TW         = $clog2(CLKS_PER_BIT);
    localparam int          BW         = $clog2(8);
    localparam int          YW         = $clog2(6);
    localparam logic [TW-1:0] TMR_MAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(7);
    localparam logic [YW-1:0] BYTE_LAST = YW'(5);
    localparam logic [23:0] PERIOD_MAX = REPORT_PERIOD - 24'd1;
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [YW-1:0] byte_q, byte_d;
    logic [31:0]   snap_q;
    logic [31:0]   snap_live;
    logic          snap_en;
    logic          pending_q, pending_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [23:0]   period_q;
    logic          tick;
    logic          trigger;
    logic          bit_end;
    logic [7:0]    cur_byte;

    // B1..B4 of the packet, packed high to low; the checksum is derived from these.
    assign snap_live = {bus.hunger, bus.happiness, bus.health, bus.hygiene,
                        bus.energy, bus.social, 1'b0, bus.status};

    assign tick    = bus.auto_en && (period_q == PERIOD_MAX);
    assign trigger = bus.send_req || tick;
    assign bit_end = (tmr_q == TMR_MAX);

    function automatic logic [7:0] byte_at(input logic [YW-1:0] idx, input logic [31:0] s);
        logic [7:0] b;
        case (idx)
            YW'(0):  b = SYNC_BYTE;
            YW'(1):  b = s[31:24];
            YW'(2):  b = s[23:16];
            YW'(3):  b = s[15:8];
            YW'(4):  b = s[7:0];
            default: b = s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
        endcase
        return b;
    endfunction

    // Free-running period counter; held at zero whenever periodic reporting is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 24'd0;
        end else if (!bus.auto_en || period_q == PERIOD_MAX) begin
            period_q <= 24'd0;
        end else begin
            period_q <= period_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            if (snap_en) begin
                snap_q <= snap_live;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        snap_en   = 1'b0;
        tx_d      = 1'b1;
        cur_byte  = 8'h00;

        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = START;
                    tmr_d     = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    pending_d = 1'b0;
                    snap_en   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tmr_d   = '0;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    tmr_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    tmr_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + YW'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Triggers arriving mid-packet (including the final stop-bit cycle) queue one packet.
        if (state_q != IDLE && trigger) begin
            pending_d = 1'b1;
        end

        // The line is registered, so it is computed from the state being entered.
        cur_byte = byte_at(byte_d, snap_q);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.uart_tx   = tx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pkt_done  = done_q;
    assign bus.fsm_state = state_q;

endmodule
